spart_rx_fifo: RTL and testbench

- Receive-side buffer between the SPART receive shift register and the bus interface that the driver polls through iocs/iorw/ioaddr/databus.
- Absorbs received bytes so the driver can miss several character times without losing data.
- Each byte is stored with its framing-error tag.
- Provides first-word-fall-through read data, level and status flags, and a sticky overrun indication for the SPART status register.

---
 rtl/spart_rx_fifo_if.sv | 37 +++
 rtl/spart_rx_fifo.sv | 117 +++++++++++
 tb/tb_spart_rx_fifo.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/spart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : spart_rx_fifo_if
//  Description : Interface bundle for the SPART receive FIFO. Carries the
//                receiver push strobe/byte/tag, the bus-side pop and
//                overrun-clear strobes, and the FWFT read data plus status.
//                slave  : FIFO side (consumes pushes/pops, drives status)
//                master : receiver/bus side (drives strobes, reads status)
//  Revision    : 1.0 - initial release
// ============================================================================
interface spart_rx_fifo_if #(
    parameter int AW = 4
);
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ferr;
    logic          rd_en;
    logic          clr_ovr;
    logic [7:0]    rd_data;
    logic          rd_ferr;
    logic          rda;
    logic          full;
    logic          almost_full;
    logic [AW:0]   level;
    logic          overrun;

    modport slave (
        input  rx_valid, rx_data, rx_ferr, rd_en, clr_ovr,
        output rd_data, rd_ferr, rda, full, almost_full, level, overrun
    );

    modport master (
        output rx_valid, rx_data, rx_ferr, rd_en, clr_ovr,
        input  rd_data, rd_ferr, rda, full, almost_full, level, overrun
    );
endinterface
`default_nettype wire

// File: rtl/spart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : spart_rx_fifo
//  Description : Receive-side FIFO between the SPART receive shift register
//                and the polled bus interface. Stores {ferr, data} per byte,
//                presents the head entry first-word-fall-through from a
//                register, and keeps level, rda/full/almost_full flags and a
//                sticky overrun indication.
//  Ports       : clk   - system clock
//                rst   - synchronous reset, active-high
//                rx_if - spart_rx_fifo_if.slave (push/pop/clear in,
//                        rd_data/rd_ferr/rda/full/almost_full/level/overrun out)
//  Revision    : 1.0 - initial release
// ============================================================================
module spart_rx_fifo #(
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int AF_LEVEL = 12
) (
    input  wire logic          clk,
    input  wire logic          rst,
    spart_rx_fifo_if.slave     rx_if
);

    localparam logic [AW:0]   c_DEPTH   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_AF      = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0]   c_LVL_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] c_PTR_ONE = AW'(1);

    // Storage: {ferr, data}; never reset
    logic [8:0]    r_mem [DEPTH];

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          r_rda;
    logic          r_full;
    logic          r_af;
    logic          r_ovr;
    logic [8:0]    r_head;

    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_bypass;
    logic [AW-1:0] w_rd_ptr_nxt;
    logic [AW:0]   w_level_nxt;

    always_comb begin
        // A pop on an empty FIFO is ignored, so a simultaneous push into an
        // empty FIFO is a plain push.
        w_pop  = rx_if.rd_en && r_rda;
        // At full, a same-cycle pop frees the slot being written.
        w_push = rx_if.rx_valid && (!r_full || w_pop);
        w_drop = rx_if.rx_valid && r_full && !w_pop;

        w_rd_ptr_nxt = w_pop ? (r_rd_ptr + c_PTR_ONE) : r_rd_ptr;

        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + c_LVL_ONE;
        end else if (w_pop && !w_push) begin
            w_level_nxt = r_level - c_LVL_ONE;
        end

        // The next head slot is the one being written this cycle, so the
        // memory still holds stale contents there: forward the incoming byte.
        w_bypass = w_push && (r_wr_ptr == w_rd_ptr_nxt);
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= {rx_if.rx_ferr, rx_if.rx_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_rda    <= 1'b0;
            r_full   <= 1'b0;
            r_af     <= 1'b0;
            r_ovr    <= 1'b0;
            r_head   <= 9'h000;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            r_rd_ptr <= w_rd_ptr_nxt;
            r_level  <= w_level_nxt;
            // Flags derive from the next level so they track level exactly.
            r_rda    <= (w_level_nxt != '0);
            r_full   <= (w_level_nxt == c_DEPTH);
            r_af     <= (w_level_nxt >= c_AF);
            r_head   <= w_bypass ? {rx_if.rx_ferr, rx_if.rx_data}
                                 : r_mem[w_rd_ptr_nxt];
            // Set wins over clear.
            if (w_drop) begin
                r_ovr <= 1'b1;
            end else if (rx_if.clr_ovr) begin
                r_ovr <= 1'b0;
            end
        end
    end

    assign rx_if.rd_data     = r_head[7:0];
    assign rx_if.rd_ferr     = r_head[8];
    assign rx_if.rda         = r_rda;
    assign rx_if.full        = r_full;
    assign rx_if.almost_full = r_af;
    assign rx_if.level       = r_level;
    assign rx_if.overrun     = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_spart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spart_rx_fifo
//  Description : Self-checking bench for spart_rx_fifo. A table of directed
//                single-cycle vectors with hand-computed expectations, then
//                hand-written multi-cycle sequences (fill/drop, boundary
//                push+pop, wrap streaming, clear-vs-drop, mid-stream reset)
//                checked against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int AF    = 12;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    spart_rx_fifo_if #(.AW(AW)) bus ();

    spart_rx_fifo #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .AF_LEVEL (AF)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rx_if (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       rst;
        logic       v;
        logic [7:0] d;
        logic       f;
        logic       re;
        logic       clr;
        logic       e_rda;
        logic       e_full;
        logic       e_af;
        logic [4:0] e_lvl;
        logic       e_ovr;
        logic       chk_d;
        logic [7:0] e_d;
        logic       e_f;
    } vec_t;

    vec_t tbl [14];

    // Reference model
    logic [8:0] q [$];
    logic       m_ovr;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [7:0] d, input logic f,
                          input logic re, input logic clr);
        bus.rx_valid = v;
        bus.rx_data  = d;
        bus.rx_ferr  = f;
        bus.rd_en    = re;
        bus.clr_ovr  = clr;
    endtask

    task automatic check_model(input string nm);
        check({nm, " level"},   32'(bus.level),       32'(q.size()));
        check({nm, " rda"},     32'(bus.rda),         32'(q.size() != 0));
        check({nm, " full"},    32'(bus.full),        32'(q.size() == DEPTH));
        check({nm, " afull"},   32'(bus.almost_full), 32'(q.size() >= AF));
        check({nm, " overrun"}, 32'(bus.overrun),     32'(m_ovr));
        if (q.size() != 0) begin
            check({nm, " rd_data"}, 32'(bus.rd_data), 32'(q[0][7:0]));
            check({nm, " rd_ferr"}, 32'(bus.rd_ferr), 32'(q[0][8]));
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic f,
                         input logic re, input logic clr, input string nm);
        bit pop_ok;
        bit push_ok;
        pop_ok  = re && (q.size() != 0);
        push_ok = v && ((q.size() < DEPTH) || pop_ok);
        if (v && !push_ok)  m_ovr = 1'b1;
        else if (clr)       m_ovr = 1'b0;
        if (pop_ok)  void'(q.pop_front());
        if (push_ok) q.push_back({f, d});
        set_in(v, d, f, re, clr);
        step();
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check_model(nm);
    endtask

    // Reset with a push strobe held high to show rst dominates.
    task automatic do_reset(input string nm);
        rst = 1'b1;
        set_in(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
        step();
        rst = 1'b0;
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        q.delete();
        m_ovr = 1'b0;
        check_model(nm);
    endtask

    initial begin
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        m_ovr = 1'b0;

        //          rst  v     d      f     re    clr   rda   full  af    lvl   ovr   chkd  d      f
        tbl[0]  = '{1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0,1'b0,1'b1,8'h00,1'b0};
        tbl[1]  = '{1'b1,1'b1,8'hFF,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,1'b0,1'b1,8'h00,1'b0};
        tbl[2]  = '{1'b0,1'b0,8'h00,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,1'b0,1'b0,8'h00,1'b0};
        tbl[3]  = '{1'b0,1'b0,8'h00,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,1'b0,1'b0,8'h00,1'b0};
        tbl[4]  = '{1'b0,1'b1,8'hA5,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,5'd1,1'b0,1'b1,8'hA5,1'b0};
        tbl[5]  = '{1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,5'd1,1'b0,1'b1,8'hA5,1'b0};
        tbl[6]  = '{1'b0,1'b0,8'h00,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,1'b0,1'b0,8'h00,1'b0};
        tbl[7]  = '{1'b0,1'b1,8'h3C,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,5'd1,1'b0,1'b1,8'h3C,1'b0};
        tbl[8]  = '{1'b0,1'b0,8'h00,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,1'b0,1'b0,8'h00,1'b0};
        tbl[9]  = '{1'b0,1'b1,8'hE1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,5'd1,1'b0,1'b1,8'hE1,1'b1};
        tbl[10] = '{1'b0,1'b1,8'h12,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,5'd2,1'b0,1'b1,8'hE1,1'b1};
        tbl[11] = '{1'b0,1'b0,8'h00,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,5'd1,1'b0,1'b1,8'h12,1'b0};
        tbl[12] = '{1'b0,1'b1,8'h34,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,5'd1,1'b0,1'b1,8'h34,1'b0};
        tbl[13] = '{1'b0,1'b0,8'h00,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,5'd0,1'b0,1'b0,8'h00,1'b0};

        for (int i = 0; i < 14; i++) begin
            rst = tbl[i].rst;
            set_in(tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].re, tbl[i].clr);
            step();
            rst = 1'b0;
            set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            check($sformatf("vec%0d rda", i),     32'(bus.rda),         32'(tbl[i].e_rda));
            check($sformatf("vec%0d full", i),    32'(bus.full),        32'(tbl[i].e_full));
            check($sformatf("vec%0d afull", i),   32'(bus.almost_full), 32'(tbl[i].e_af));
            check($sformatf("vec%0d level", i),   32'(bus.level),       32'(tbl[i].e_lvl));
            check($sformatf("vec%0d overrun", i), 32'(bus.overrun),     32'(tbl[i].e_ovr));
            if (tbl[i].chk_d) begin
                check($sformatf("vec%0d rd_data", i), 32'(bus.rd_data), 32'(tbl[i].e_d));
                check($sformatf("vec%0d rd_ferr", i), 32'(bus.rd_ferr), 32'(tbl[i].e_f));
            end
        end

        // Fill, drop, boundary push+pop at full, drain in order
        do_reset("fill reset");
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, $sformatf("fill%0d", i));
        end
        drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, "drop55");
        check("drop55 overrun const", 32'(bus.overrun), 32'd1);
        drive(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, "full push+pop");
        check("full push+pop level", 32'(bus.level), 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, $sformatf("drain%0d", i));
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "clr overrun");

        // Streaming across the pointer wrap with rd_en held
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, (i == 20) ? 8'hE1 : 8'(i * 7 + 3), (i == 20), 1'b1, 1'b0,
                  $sformatf("stream%0d", i));
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "stream drain");

        // Clear and drop in the same cycle: set wins
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0, $sformatf("refill%0d", i));
        end
        drive(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, "clr+drop");
        check("clr+drop overrun const", 32'(bus.overrun), 32'd1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "clr alone");

        // Reset mid-stream
        do_reset("mid reset pre");
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0, $sformatf("pre%0d", i));
        end
        do_reset("mid reset");
        drive(1'b1, 8'h99, 1'b0, 1'b0, 1'b0, "post reset push");
        check("post reset rd_data const", 32'(bus.rd_data), 32'h99);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "post reset pop");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
